inv_key_sched: RTL and testbench
================================

INV_KEY_SCHED -- requirements
Module: inv_key_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; ports are listed in REQ-002..REQ-010.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  request to begin an inverse expansion; sampled only in IDLE.
REQ-005 key_in  in  128  round-10 (final) AES-128 round key; col1=[127:96] .. col4=[31:0].
REQ-006 key_out  out  128  current round key, registered.
REQ-007 round_out  out  4  round index of key_out (10 down to 0).
REQ-008 key_valid  out  1  key_out/round_out valid.
REQ-009 key_ready  in  1  consumer accepts key_out when high with key_valid.
REQ-010 busy  out  1  high in any state other than IDLE; done  out  1  one-cycle pulse after round-0 key accepted.

Function
REQ-011 FSM states SHALL be IDLE, EMIT; busy = (state != IDLE).
REQ-012 IDLE & start at edge T: key register <= key_in, round_cnt <= 10, state <= EMIT, key_valid = 1 from T+1.
REQ-013 start while busy SHALL be ignored; key_in SHALL only be sampled on the accepting edge.
REQ-014 Handshake: transfer occurs on an edge where key_valid & key_ready; key_out/round_out SHALL stay stable while key_valid & !key_ready.
REQ-015 On transfer with round_cnt > 0: key register <= prev(key), round_cnt <= round_cnt - 1, key_valid stays 1.
REQ-016 prev(K={c1,c2,c3,c4}) = {p1,p2,p3,p4}: p4 = c4^c3; p3 = c3^c2; p2 = c2^c1; p1 = c1 ^ SubWord(RotWord(p4)) ^ Rcon(round_cnt-1).
REQ-017 RotWord(w) = {w[23:0], w[31:24]}; SubWord applies the AES forward S-box to each byte.
REQ-018 Rcon(i), i=0..9: 01,02,04,08,10,20,40,80,1b,36 in bits [31:24], zero elsewhere; other i give 0.
REQ-019 prev() SHALL be combinational within one cycle; throughput one key per cycle with key_ready held high.
REQ-020 On transfer with round_cnt == 0: state <= IDLE, key_valid <= 0, done = 1 for exactly the next cycle.
REQ-021 start in the same cycle done is high SHALL be accepted (state is IDLE).
REQ-022 Full run with key_ready high: 11 keys on cycles T+1..T+11, done at T+12.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, key_valid=0, done=0, busy=0, round_out=0, key_out=0, regardless of activity.
REQ-024 Reset mid-run SHALL abort; after release no key is emitted until a new start.

Structure
REQ-025 Rcon table, round count (10) and state encoding SHALL live in the shared AES package.
REQ-026 A combinational byte S-box sub-module aes_sbox SHALL be instantiated four times for SubWord.

Verification
REQ-027 FIPS-197 A.1: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 -> round 10 = key_in, round 9 = ac7766f319fadc2128d12941575c006e, round 0 = 2b7e151628aed2a6abf7158809cf4f3c, done at T+12.
REQ-028 Same run with key_ready low for 3 cycles at round 5 -> key_out/round_out held, no key skipped or duplicated.
REQ-029 start pulsed at round 7 -> ignored; sequence completes unchanged.
REQ-030 rst_n asserted at round 4 -> all outputs zero asynchronously; no key_valid until next start.
REQ-031 start in done cycle with a second key -> second run's round 10 appears next cycle, back to back.

Source files
------------

// File: rtl/inv_key_sched_pkg.sv
// Shared AES definitions for the inverse key schedule.
//   state_t    : FSM state encoding (IDLE / EMIT)
//   NUM_ROUNDS : AES-128 round count; the expansion starts from this round
//   rcon()     : round constant word, Rcon(i) in bits [31:24]
package inv_key_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    // Indices 10..15 return zero; the wrap from round 0 to 4'hf lands there.
    function automatic logic [31:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte lookup.
//   din  : input byte
//   dout : S(din)
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Entry 0 sits in the most significant byte, so the table reads in the
    // usual row order.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0] idx_rev;

    assign idx_rev = 8'hff - din;
    assign dout    = SBOX_TBL[{idx_rev, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_sched.sv
// AES-128 inverse key expansion: starting from the round-10 key, emits the
// round keys 10 down to 0 over a valid/ready handshake, one per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a run (honoured only when idle)
//   key_in     : round-10 key, sampled on the accepting edge
//   key_out    : current round key (col1 in [127:96])
//   round_out  : round index of key_out
//   key_valid  : key_out/round_out valid
//   key_ready  : consumer accepts key_out this cycle
//   busy       : run in progress
//   done       : one-cycle pulse after the round-0 key is taken
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | waiting for start; outputs hold last values
// ST_EMIT | key_out valid; step back one round per transfer
module inv_key_sched
    import inv_key_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d, key_prev;
    logic [3:0]   round_q, round_d;
    logic         done_d;

    logic [31:0]  c1, c2, c3, c4;
    logic [31:0]  p1, p2, p3, p4;
    logic [31:0]  rot_w, sub_w;

    // Undo one forward expansion step: the last three columns fall out of
    // XOR chaining, and the recovered p4 feeds the g() function for p1.
    assign {c1, c2, c3, c4} = key_q;
    assign p4    = c4 ^ c3;
    assign p3    = c3 ^ c2;
    assign p2    = c2 ^ c1;
    assign rot_w = {p4[23:0], p4[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (rot_w[8*i +: 8]),
            .dout (sub_w[8*i +: 8])
        );
    end

    assign p1       = c1 ^ sub_w ^ rcon(round_q - 4'd1);
    assign key_prev = {p1, p2, p3, p4};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = NUM_ROUNDS;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (key_ready) begin
                    if (round_q != 4'd0) begin
                        key_d   = key_prev;
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign key_out   = key_q;
    assign round_out = round_q;
    assign key_valid = (state_q == ST_EMIT);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_inv_key_sched.sv
// Bench for inv_key_sched. Reference round keys come from an independent
// forward AES-128 key expansion whose S-box is derived from GF(2^8)
// inversion plus the affine map. Each accepted start queues the 11 expected
// (round, key) pairs; a negedge monitor compares the head of the queue
// whenever key_valid is high and pops it on a transfer.
module tb_inv_key_sched;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         key_valid;
    logic         busy;
    logic         done;

    inv_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_out   (key_out),
        .round_out (round_out),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         sb[$];
    logic [7:0]   sbox_m [256];
    logic [127:0] rk_tab [0:10];
    int           n_checks = 0;
    int           n_pass   = 0;
    bit           exp_done = 1'b0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward expansion of the round-0 key into rk_tab[0..10].
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called just after a posedge while the DUT is idle (or in its done
    // cycle); start is accepted on the next edge.
    task automatic start_run(input logic [127:0] k0);
        expand(k0);
        key_in = rk_tab[10];
        start  = 1'b1;
        @(posedge clk);
        for (int r = 10; r >= 0; r--) sb.push_back('{rnd: 4'(r), key: rk_tab[r]});
        #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // mode 0: ready high, check latency   1: stall 3 cycles at round 5
    // mode 2: start pulse at round 7      3: reset at round 4
    // mode 4: random ready
    task automatic run_key(input logic [127:0] k0, input int mode);
        int n;
        bit fired;
        n = 0;
        fired = 1'b0;
        start_run(k0);
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (mode == 4) key_ready = ($urandom_range(0, 3) != 0);
            if (done) break;
            if (!fired && key_valid) begin
                if (mode == 1 && round_out == 4'd5) begin
                    fired = 1'b1;
                    key_ready = 1'b0;
                    repeat (3) @(posedge clk);
                    #1;
                    key_ready = 1'b1;
                    n += 3;
                end else if (mode == 2 && round_out == 4'd7) begin
                    fired = 1'b1;
                    start  = 1'b1;
                    key_in = {$urandom, $urandom, $urandom, $urandom};
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    n++;
                end else if (mode == 3 && round_out == 4'd4) begin
                    #1;
                    rst_n = 1'b0;
                    sb.delete();
                    exp_done = 1'b0;
                    #1;
                    chk("rst_key_out", key_out, '0);
                    chk("rst_round_out", round_out, 4'd0);
                    chk("rst_key_valid", key_valid, 1'b0);
                    chk("rst_busy", busy, 1'b0);
                    chk("rst_done", done, 1'b0);
                    repeat (2) @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    repeat (6) @(posedge clk);
                    #1;
                    chk("no_valid_after_reset", key_valid, 1'b0);
                    key_ready = 1'b1;
                    return;
                end
            end
        end
        key_ready = 1'b1;
        chk("done_seen", done, 1'b1);
        // Round-0 transfer lands on the 11th edge after the accepting edge.
        if (mode == 0) chk("done_latency", n, 11);
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("busy", busy, sb.size() != 0);
        chk("done", done, exp_done);
        exp_done = 1'b0;
        if (key_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", key_valid, 1'b0);
            end else begin
                chk("round_out", round_out, sb[0].rnd);
                chk("key_out", key_out, sb[0].key);
                if (key_ready) begin
                    e = sb.pop_front();
                    if (e.rnd == 4'd0) exp_done = 1'b1;
                end
            end
        end
    end

    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        key_in    = '0;
        key_ready = 1'b1;
        build_sbox();
        #1;
        chk("init_key_out", key_out, '0);
        chk("init_round_out", round_out, 4'd0);
        chk("init_key_valid", key_valid, 1'b0);
        chk("init_busy", busy, 1'b0);
        chk("init_done", done, 1'b0);

        expand(FIPS_K0);
        chk("model_r10", rk_tab[10], FIPS_K10);
        chk("model_r9", rk_tab[9], FIPS_K9);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_key(FIPS_K0, 0);
        run_key(FIPS_K0, 1);
        run_key(FIPS_K0, 2);
        run_key(FIPS_K0, 3);
        run_key({$urandom, $urandom, $urandom, $urandom}, 0);
        for (int i = 0; i < 40; i++)
            run_key({$urandom, $urandom, $urandom, $urandom}, 4);

        repeat (4) @(posedge clk);
        #1;
        chk("end_idle_valid", key_valid, 1'b0);
        chk("end_queue_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
